// File: rtl/crc_frame_check_pkg.sv
// Shared constants, FSM state type and CRC helper for the frame checker.
// Used by the RTL and by the bench-side engine model.
package crc_frame_check_pkg;

    localparam logic [2:0] STEP_CLR = 3'd1;
    localparam logic [2:0] STEP_SHIFT = 3'd5;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SETTLE,
        CHECK
    } state_t;

    // One serial CRC-32 step, MSB-first.
    function automatic logic [31:0] crc_next(
        input logic [31:0] crc,
        input logic din
    );
        crc_next = {crc[30:0], 1'b0} ^ ((crc[31] ^ din) ? CRC_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/crc_frame_check_fcs_capture.sv
// Received-FCS nibble collector: shift register, nibble count, overrun.
// Nibbles arrive MS-first and are shifted in at the LSB end.
module fcs_capture #(
    parameter int CRC_W = 32,
    parameter int FCS_NIB = 8,
    parameter int NCNT_W = $clog2(FCS_NIB + 1)
) (
    input  logic              clk_100Mz,
    input  logic              rst,
    input  logic              clr,
    input  logic              fcs_valid,
    input  logic [3:0]        fcs_nib,
    output logic [CRC_W-1:0]  fcs_sr,
    output logic [NCNT_W-1:0] count,
    output logic              overrun
);

    always_ff @(posedge clk_100Mz or posedge rst) begin
        if (rst) begin
            fcs_sr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (clr) begin
            fcs_sr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (fcs_valid) begin
            if (count < NCNT_W'(FCS_NIB)) begin
                fcs_sr <= {fcs_sr[CRC_W-5:0], fcs_nib};
                count  <= count + 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/crc_frame_check.sv
// Frame CRC verdict block: FSM, remainder capture, compare and
// saturating good/bad frame counters.
module crc_frame_check
    import crc_frame_check_pkg::*;
#(
    parameter int CRC_W = 32,
    parameter int FCS_NIB = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_100Mz,
    input  logic             rst,
    input  logic [2:0]       step,
    input  logic [CRC_W:0]   buff_data_crc,
    input  logic             fcs_valid,
    input  logic [3:0]       fcs_nib,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             len_err,
    output logic             busy,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam int NCNT_W = $clog2(FCS_NIB + 1);

    state_t            state;
    state_t            state_nx;
    logic              clr;
    logic              cap_en;
    logic              check_en;
    logic [CRC_W-1:0]  crc_cap;
    logic [CRC_W-1:0]  fcs_sr;
    logic [NCNT_W-1:0] count;
    logic              overrun;
    logic              len_bad;
    logic              ok_now;
    logic              unused_top;

    assign unused_top = buff_data_crc[CRC_W];
    assign clr = (step == STEP_CLR);

    fcs_capture #(
        .CRC_W  (CRC_W),
        .FCS_NIB(FCS_NIB),
        .NCNT_W (NCNT_W)
    ) u_fcs_capture (
        .clk_100Mz(clk_100Mz),
        .rst      (rst),
        .clr      (clr),
        .fcs_valid(fcs_valid),
        .fcs_nib  (fcs_nib),
        .fcs_sr   (fcs_sr),
        .count    (count),
        .overrun  (overrun)
    );

    always_ff @(posedge clk_100Mz or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (step == STEP_SHIFT) state_nx = COLLECT;
                COLLECT: if (step != STEP_SHIFT) state_nx = SETTLE;
                SETTLE:  state_nx = CHECK;
                CHECK:   state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        cap_en   = (state == SETTLE) && !clr;
        check_en = (state == CHECK) && !clr;
    end

    assign len_bad = (count != NCNT_W'(FCS_NIB)) || overrun;
    assign ok_now  = (crc_cap == fcs_sr) && !len_bad;

    // A clear landing on the CHECK edge aborts the frame: no verdict, no count.
    always_ff @(posedge clk_100Mz or posedge rst) begin
        if (rst) begin
            crc_cap  <= '0;
            done     <= 1'b0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            len_err  <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            done <= check_en;
            if (cap_en) crc_cap <= buff_data_crc[CRC_W-1:0];
            if (clr) begin
                crc_ok  <= 1'b0;
                crc_err <= 1'b0;
                len_err <= 1'b0;
            end else if (check_en) begin
                crc_ok  <= ok_now;
                crc_err <= !ok_now;
                len_err <= len_bad;
                if (ok_now) begin
                    if (good_cnt != '1) good_cnt <= good_cnt + 1'b1;
                end else begin
                    if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_frame_check.sv
// Scoreboard bench for crc_frame_check, with a narrow-counter twin
// instance used to reach counter saturation quickly.
module tb_crc_frame_check;
    import crc_frame_check_pkg::*;

    logic        clk_100Mz = 1'b0;
    logic        rst;
    logic [2:0]  step;
    logic [32:0] buff_data_crc;
    logic        fcs_valid;
    logic [3:0]  fcs_nib;

    logic        done, crc_ok, crc_err, len_err, busy;
    logic [15:0] good_cnt, bad_cnt;
    logic        done2, crc_ok2, crc_err2, len_err2, busy2;
    logic [1:0]  good_cnt2, bad_cnt2;

    crc_frame_check u_dut (
        .clk_100Mz    (clk_100Mz),
        .rst          (rst),
        .step         (step),
        .buff_data_crc(buff_data_crc),
        .fcs_valid    (fcs_valid),
        .fcs_nib      (fcs_nib),
        .done         (done),
        .crc_ok       (crc_ok),
        .crc_err      (crc_err),
        .len_err      (len_err),
        .busy         (busy),
        .good_cnt     (good_cnt),
        .bad_cnt      (bad_cnt)
    );

    crc_frame_check #(.CNT_W(2)) u_sat (
        .clk_100Mz    (clk_100Mz),
        .rst          (rst),
        .step         (step),
        .buff_data_crc(buff_data_crc),
        .fcs_valid    (fcs_valid),
        .fcs_nib      (fcs_nib),
        .done         (done2),
        .crc_ok       (crc_ok2),
        .crc_err      (crc_err2),
        .len_err      (len_err2),
        .busy         (busy2),
        .good_cnt     (good_cnt2),
        .bad_cnt      (bad_cnt2)
    );

    always #5 clk_100Mz = ~clk_100Mz;

    typedef struct {
        logic        ok;
        logic        err;
        logic        len;
        logic [15:0] good;
        logic [15:0] bad;
        logic [1:0]  good2;
        logic [1:0]  bad2;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] m_good = '0;
    logic [15:0] m_bad = '0;
    logic [1:0]  m_good2 = '0;
    logic [1:0]  m_bad2 = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk_100Mz) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", done, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("crc_ok", crc_ok, e.ok);
                chk("crc_err", crc_err, e.err);
                chk("len_err", len_err, e.len);
                chk("good_cnt", good_cnt, e.good);
                chk("bad_cnt", bad_cnt, e.bad);
                chk("good_cnt_sat", good_cnt2, e.good2);
                chk("bad_cnt_sat", bad_cnt2, e.bad2);
            end
        end
    end

    function automatic logic [3:0] nib_at(input logic [63:0] nibs, input int i);
        nib_at = nibs[63-4*i -: 4];
    endfunction

    // Starts and ends on a falling edge.
    task automatic run_frame(input logic [31:0] crc_final, input int nnib,
                             input logic [63:0] nibs, input bit abort,
                             input bit linger);
        logic [31:0] fcs;
        bit          ok;
        step = STEP_CLR;
        fcs_valid = 1'b0;
        @(negedge clk_100Mz);
        chk("clr_ok", crc_ok, 1'b0);
        chk("clr_err", crc_err, 1'b0);
        chk("clr_len", len_err, 1'b0);
        chk("clr_busy", busy, 1'b0);
        for (int i = 0; i < 32; i++) begin
            step = STEP_SHIFT;
            fcs_valid = (i < nnib);
            fcs_nib = nib_at(nibs, i);
            @(posedge clk_100Mz);
            #1;
            if (i == 31) buff_data_crc = {1'b0, crc_final};
            else buff_data_crc = {1'b0, crc_next(buff_data_crc[31:0], 1'($urandom))};
            @(negedge clk_100Mz);
        end
        step = 3'd0;
        fcs_valid = 1'b0;
        fcs = '0;
        for (int i = 0; i < nnib && i < 8; i++) fcs = {fcs[27:0], nib_at(nibs, i)};
        ok = (nnib == 8) && (fcs == crc_final);
        if (abort) begin
            @(negedge clk_100Mz);
            step = STEP_CLR;
            @(negedge clk_100Mz);
            step = 3'd0;
            chk("abort_busy", busy, 1'b0);
            chk("abort_ok", crc_ok, 1'b0);
            chk("abort_err", crc_err, 1'b0);
            chk("abort_len", len_err, 1'b0);
            chk("abort_good", good_cnt, m_good);
            chk("abort_bad", bad_cnt, m_bad);
            repeat (3) begin
                @(negedge clk_100Mz);
                chk("abort_nodone", done, 1'b0);
            end
        end else begin
            if (ok) begin
                if (m_good != 16'hFFFF) m_good++;
                if (m_good2 != 2'b11) m_good2++;
            end else begin
                if (m_bad != 16'hFFFF) m_bad++;
                if (m_bad2 != 2'b11) m_bad2++;
            end
            sb.push_back('{ok, !ok, nnib != 8, m_good, m_bad, m_good2, m_bad2});
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk_100Mz);
                if (k == 1) chk("busy_settle", busy, 1'b1);
                chk("latency", done, k == 3);
                if (linger) step = (k < 3) ? STEP_SHIFT : 3'd0;
            end
            @(negedge clk_100Mz);
            chk("done_pulse", done, 1'b0);
            chk("idle_after", busy, 1'b0);
            chk("hold_ok", crc_ok, ok);
        end
    endtask

    initial begin
        rst = 1'b1;
        step = 3'd0;
        buff_data_crc = '0;
        fcs_valid = 1'b0;
        fcs_nib = 4'h0;
        #1;
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_good", good_cnt, 16'h0);
        chk("rst_bad", bad_cnt, 16'h0);
        @(negedge clk_100Mz);
        rst = 1'b0;
        @(negedge clk_100Mz);

        run_frame(32'h1234ABCD, 8, 64'h1234ABCD_00000000, 0, 0);
        run_frame(32'h1234ABCD, 8, 64'h1234ABCE_00000000, 0, 1);
        run_frame(32'h1234ABCD, 7, 64'h1234ABC0_00000000, 0, 0);
        run_frame(32'h1234ABCD, 9, 64'h1234ABCD_F0000000, 0, 0);
        run_frame(32'h1234ABCD, 8, 64'h1234ABCD_00000000, 1, 0);
        run_frame(32'hDEADBEEF, 8, 64'hDEADBEEE_00000000, 0, 0);
        run_frame(32'h0F0F0F0F, 8, 64'h0F0F0F0E_00000000, 0, 0);
        run_frame(32'hCAFE0001, 8, 64'hCAFE0001_00000000, 0, 0);

        step = STEP_CLR;
        @(negedge clk_100Mz);
        repeat (4) begin
            step = STEP_SHIFT;
            fcs_valid = 1'b1;
            fcs_nib = 4'h7;
            @(negedge clk_100Mz);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_ok", crc_ok, 1'b0);
        chk("arst_err", crc_err, 1'b0);
        chk("arst_len", len_err, 1'b0);
        chk("arst_good", good_cnt, 16'h0);
        chk("arst_bad", bad_cnt, 16'h0);
        chk("arst_good_sat", good_cnt2, 2'b00);
        #1;
        rst = 1'b0;
        step = 3'd0;
        fcs_valid = 1'b0;
        m_good = '0;
        m_bad = '0;
        m_good2 = '0;
        m_bad2 = '0;
        repeat (4) @(negedge clk_100Mz);
        chk("arst_idle", busy, 1'b0);

        run_frame(32'h1234ABCD, 8, 64'h1234ABCD_00000000, 0, 0);

        repeat (3) @(negedge clk_100Mz);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
